// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} dmem_size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int DMEM_CNT_W = 4;
  function automatic logic [2:0] align_mask(input dmem_size_t s);
    return 3'((4'd1 << s) - 4'd1);
  endfunction
endpackage

// File: rtl/dmem_lanes.sv
// dmem_lanes: byte-enable, write-data shift and read-data extract for one 64-bit word
module dmem_lanes
  import dmem_pkg::*;
(
  input  dmem_size_t  i_size,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rword,
  output logic [7:0]  o_be,
  output logic [63:0] o_wdata,
  output logic [63:0] o_rdata
);
  logic [63:0] w_mask;
  logic [7:0]  w_lanes;
  logic [15:0] w_be_wide;
  assign w_mask    = (i_size == SZ_D) ? '1 : (64'd1 << (6'd8 << i_size)) - 64'd1;
  assign w_lanes   = {w_mask[56], w_mask[48], w_mask[40], w_mask[32],
                      w_mask[24], w_mask[16], w_mask[8], w_mask[0]};
  assign w_be_wide = {8'd0, w_lanes} << i_off;
  assign o_be      = w_be_wide[7:0];
  assign o_wdata   = (i_wdata & w_mask) << {i_off, 3'b000};
  assign o_rdata   = (i_rword >> {i_off, 3'b000}) & w_mask;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated valid/ready data-memory responder; DMEM_RESP_ERR_EN enables alignment/range faults
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DMEM_CNT_W-1:0] WC = DMEM_CNT_W'(WAIT_CYCLES);
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > (1 << DMEM_CNT_W) - 1) begin : g_bad_wait
    $error("WAIT_CYCLES out of range 0..15");
  end
  dmem_state_t           r_state;
  logic [DMEM_CNT_W-1:0] r_cnt;
  logic                  r_we;
  logic [63:0]           r_addr;
  dmem_size_t            r_size;
  logic [63:0]           r_wdata;
  logic                  r_ready;
  logic                  r_valid;
  logic [63:0]           r_rdata;
  logic                  r_err;
  logic [63:0]           r_mem [DEPTH_WORDS];
  logic                  w_idle;
  logic                  w_acc;
  logic                  w_we;
  logic [63:0]           w_addr;
  dmem_size_t            w_size;
  logic [63:0]           w_wdata;
  logic [2:0]            w_amask;
  logic [2:0]            w_off;
  logic                  w_fault;
  logic [AW-1:0]         w_idx;
  logic [7:0]            w_be;
  logic [63:0]           w_lwdata;
  logic [63:0]           w_lrdata;
  // With zero wait states the access happens on the accept edge, so use live request fields in IDLE
  assign w_idle  = r_state == IDLE;
  assign w_we    = w_idle ? req_we : r_we;
  assign w_addr  = w_idle ? req_addr : r_addr;
  assign w_size  = w_idle ? dmem_size_t'(req_size) : r_size;
  assign w_wdata = w_idle ? req_wdata : r_wdata;
  assign w_acc   = reset && (w_idle ? (req_valid && WAIT_CYCLES == 0) : (r_state == WAIT && r_cnt == 1));
  assign w_amask = align_mask(w_size);
`ifdef DMEM_RESP_ERR_EN
  assign w_off   = w_addr[2:0];
  assign w_fault = |(w_addr[2:0] & w_amask) || (w_addr[63:3] >= 61'(DEPTH_WORDS));
  assign w_idx   = AW'(w_addr[63:3]);
`else
  assign w_off   = w_addr[2:0] & ~w_amask;
  assign w_fault = 1'b0;
  assign w_idx   = AW'(w_addr[63:3] % 61'(DEPTH_WORDS));
`endif
  dmem_lanes u_lanes (
    .i_size (w_size),
    .i_off  (w_off),
    .i_wdata(w_wdata),
    .i_rword(r_mem[w_idx]),
    .o_be   (w_be),
    .o_wdata(w_lwdata),
    .o_rdata(w_lrdata)
  );
  always_ff @(posedge clk) begin
    if (w_acc && w_we && !w_fault)
      for (int b = 0; b < 8; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_lwdata[b*8 +: 8];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= SZ_B;
      r_wdata <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_rdata <= (w_we || w_fault) ? '0 : w_lrdata;
        r_err   <= w_fault;
      end
      case (r_state)
        IDLE: if (req_valid) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_size  <= dmem_size_t'(req_size);
          r_wdata <= req_wdata;
          r_cnt   <= WC;
          r_ready <= 1'b0;
          r_valid <= WAIT_CYCLES == 0;
          if (WAIT_CYCLES == 0) r_state <= RESP;
          else r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 1) begin
            r_state <= RESP;
            r_valid <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready = r_ready;
  assign rsp_valid = r_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_dmem_responder;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  logic        clk = 1'b0;
  logic        a_reset, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_err;
  logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [1:0]  a_req_size;
  logic        z_reset, z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_err;
  logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [1:0]  z_req_size;
  int          n_vec = 0;
  int          n_err = 0;
  vec_t        vt [19];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_addr(a_req_addr), .req_size(a_req_size), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_z (
    .clk(clk), .reset(z_reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic xact(input bit sel, input logic we, input logic [63:0] addr, input logic [1:0] size,
                      input logic [63:0] wdata, output logic [63:0] rd, output logic er,
                      output int lat, output logic wide);
    int g;
    @(negedge clk);
    if (sel) begin
      z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_size = size; z_req_wdata = wdata;
    end else begin
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_size = size; a_req_wdata = wdata;
    end
    g = 0;
    while (!(sel ? z_req_ready : a_req_ready) && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    if (sel) z_req_valid = 1'b0;
    else a_req_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (sel ? z_rsp_valid : a_rsp_valid) break;
    end
    rd = sel ? z_rsp_rdata : a_rsp_rdata;
    er = sel ? z_rsp_err : a_rsp_err;
    @(negedge clk);
    wide = sel ? z_rsp_valid : a_rsp_valid;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] rd;
    logic        er, wide;
    int          lat, g, seen;
    vt[0]  = '{1'b1, 64'h10, 2'd3, 64'h1122334455667788, 64'h0, 1'b0};
    vt[1]  = '{1'b0, 64'h10, 2'd3, 64'h0, 64'h1122334455667788, 1'b0};
    vt[2]  = '{1'b1, 64'h13, 2'd0, 64'hFFFFFFFFFFFFFFAB, 64'h0, 1'b0};
    vt[3]  = '{1'b0, 64'h10, 2'd3, 64'h0, 64'h11223344AB667788, 1'b0};
    vt[4]  = '{1'b0, 64'h16, 2'd1, 64'h0, 64'h1122, 1'b0};
    vt[5]  = '{1'b0, 64'h17, 2'd0, 64'h0, 64'h11, 1'b0};
    vt[6]  = '{1'b0, 64'h12, 2'd2, 64'h0, ERR ? 64'h0 : 64'hAB667788, ERR};
    vt[7]  = '{1'b1, 64'h0, 2'd3, 64'h0123456789ABCDEF, 64'h0, 1'b0};
    vt[8]  = '{1'b1, 64'h800, 2'd3, 64'hFFFFFFFFFFFFFFFF, 64'h0, ERR};
    vt[9]  = '{1'b0, 64'h0, 2'd3, 64'h0, ERR ? 64'h0123456789ABCDEF : 64'hFFFFFFFFFFFFFFFF, 1'b0};
    vt[10] = '{1'b0, 64'h800, 2'd3, 64'h0, ERR ? 64'h0 : 64'hFFFFFFFFFFFFFFFF, ERR};
    vt[11] = '{1'b1, 64'h18, 2'd3, 64'h0, 64'h0, 1'b0};
    vt[12] = '{1'b1, 64'h1A, 2'd1, 64'h1234BEEF, 64'h0, 1'b0};
    vt[13] = '{1'b1, 64'h1C, 2'd2, 64'hCAFEF00D, 64'h0, 1'b0};
    vt[14] = '{1'b0, 64'h18, 2'd3, 64'h0, 64'hCAFEF00DBEEF0000, 1'b0};
    vt[15] = '{1'b0, 64'h1C, 2'd2, 64'h0, 64'hCAFEF00D, 1'b0};
    vt[16] = '{1'b0, 64'h1B, 2'd0, 64'h0, 64'hBE, 1'b0};
    vt[17] = '{1'b1, 64'h20, 2'd3, 64'h0F0E0D0C0B0A0908, 64'h0, 1'b0};
    vt[18] = '{1'b0, 64'h20, 2'd3, 64'h0, 64'h0F0E0D0C0B0A0908, 1'b0};
    a_reset = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_size = '0; a_req_wdata = '0;
    z_reset = 1'b0; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_size = '0; z_req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", a_req_ready, 1);
    chk("reset rsp_valid", a_rsp_valid, 0);
    chk("reset rsp_rdata", a_rsp_rdata, 0);
    chk("reset rsp_err", a_rsp_err, 0);
    a_reset = 1'b1;
    z_reset = 1'b1;
    for (int i = 0; i < 19; i++) begin
      xact(1'b0, vt[i].we, vt[i].addr, vt[i].size, vt[i].wdata, rd, er, lat, wide);
      chk($sformatf("v%0d latency", i), 64'(lat), 3);
      chk($sformatf("v%0d rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("v%0d err", i), 64'(er), 64'(vt[i].exp_err));
      chk($sformatf("v%0d pulse width", i), 64'(wide), 0);
    end
    // Request fields change and req_valid stays up after accept: must be ignored
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 64'h28; a_req_size = 2'd3; a_req_wdata = 64'h5A5A5A5AA5A5A5A5;
    @(posedge clk);
    #1;
    a_req_addr = 64'h20; a_req_size = 2'd0; a_req_wdata = '1;
    @(negedge clk);
    chk("busy req_ready", a_req_ready, 0);
    a_req_valid = 1'b0;
    g = 0;
    while (!a_rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("held rsp_valid", a_rsp_valid, 1);
    xact(1'b0, 1'b0, 64'h28, 2'd3, 64'h0, rd, er, lat, wide);
    chk("sampled fields ld 0x28", rd, 64'h5A5A5A5AA5A5A5A5);
    xact(1'b0, 1'b0, 64'h20, 2'd3, 64'h0, rd, er, lat, wide);
    chk("ignored fields ld 0x20", rd, 64'h0F0E0D0C0B0A0908);
    // Reset pulsed during WAIT of a store: store discarded, no response
    @(negedge clk);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 64'h20; a_req_size = 2'd3; a_req_wdata = 64'hDEADDEADDEADDEAD;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    a_reset = 1'b0;
    #1;
    chk("mid reset req_ready", a_req_ready, 1);
    chk("mid reset rsp_rdata", a_rsp_rdata, 0);
    @(negedge clk);
    a_reset = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_rsp_valid) seen++;
    end
    chk("dropped rsp_valid count", 64'(seen), 0);
    chk("post reset req_ready", a_req_ready, 1);
    xact(1'b0, 1'b0, 64'h20, 2'd3, 64'h0, rd, er, lat, wide);
    chk("discarded store ld 0x20", rd, 64'h0F0E0D0C0B0A0908);
    // Zero wait states
    xact(1'b1, 1'b1, 64'h40, 2'd3, 64'h8877665544332211, rd, er, lat, wide);
    chk("w0 store latency", 64'(lat), 1);
    chk("w0 store pulse width", 64'(wide), 0);
    xact(1'b1, 1'b0, 64'h44, 2'd2, 64'h0, rd, er, lat, wide);
    chk("w0 load latency", 64'(lat), 1);
    chk("w0 load rdata", rd, 64'h88776655);
    chk("w0 load err", 64'(er), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
